// File: rtl/rgmii_rx_clk_speed_detector.sv
// Classifies the RGMII RX link speed by counting edges of the divided RX clock
// over fixed clk250 windows and commits a TX clock setting after repeated agreement.
module rgmii_rx_clk_speed_detector #(
   parameter int unsigned window_cycles_p  = 4096,
   parameter int unsigned thr_1000_p       = 160,
   parameter int unsigned thr_100_p        = 24,
   parameter int unsigned thr_10_p         = 2,
   parameter int unsigned stable_windows_p = 3,
   parameter int unsigned cnt_width_p      = 10
) (
   input  logic                   clk250_i,
   input  logic                   clk250_rst_ni,
   input  logic                   rx_clk_div8_i,
   output logic [1:0]             speed_setting_o,
   output logic                   speed_valid_o,
   output logic                   speed_change_o,
   output logic [cnt_width_p-1:0] edge_count_o
);

   localparam int unsigned WC_W    = $clog2(window_cycles_p);
   localparam int unsigned AGREE_W = $clog2(stable_windows_p + 1);

   localparam logic [WC_W-1:0]        WC_LAST   = WC_W'(window_cycles_p - 1);
   localparam logic [cnt_width_p-1:0] CNT_MAX   = '1;
   localparam logic [AGREE_W-1:0]     AGREE_MAX = AGREE_W'(stable_windows_p);

   // Class encoding doubles as the TX clock setting; CLS_NONE never reaches the output.
   typedef enum logic [1:0] {
      CLS_1000 = 2'b00,
      CLS_100  = 2'b01,
      CLS_10   = 2'b10,
      CLS_NONE = 2'b11
   } cls_e;

   if (!((thr_1000_p > thr_100_p) && (thr_100_p > thr_10_p))) begin : g_bad_thresholds
      $error("rgmii_rx_clk_speed_detector: thresholds must satisfy thr_1000_p > thr_100_p > thr_10_p");
   end
   if ((window_cycles_p < 256) || ((window_cycles_p & (window_cycles_p - 1)) != 0)) begin : g_bad_window
      $error("rgmii_rx_clk_speed_detector: window_cycles_p must be a power of two >= 256");
   end
   if (stable_windows_p < 1) begin : g_bad_stable
      $error("rgmii_rx_clk_speed_detector: stable_windows_p must be at least 1");
   end

   logic                   sync1_q, sync2_q, sync3_q;
   logic                   rx_rise_c;
   logic [WC_W-1:0]        wc_q;
   logic                   win_last_c;
   logic [cnt_width_p-1:0] edge_cnt_q;
   logic [cnt_width_p-1:0] count_sat_c;
   cls_e                   win_cls_c;

   cls_e                   committed_q, committed_d;
   cls_e                   cand_q, cand_d;
   logic [AGREE_W-1:0]     agree_q, agree_d;
   logic [1:0]             setting_d;
   logic                   valid_d;
   logic                   change_d;

   // Two-flop synchronizer plus a history flop for rising-edge detection.
   always_ff @(posedge clk250_i or negedge clk250_rst_ni) begin
      if (!clk250_rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= rx_clk_div8_i;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign rx_rise_c   = sync2_q & ~sync3_q;
   assign win_last_c  = (wc_q == WC_LAST);
   assign count_sat_c = (edge_cnt_q == CNT_MAX) ? CNT_MAX
                                                : edge_cnt_q + cnt_width_p'(rx_rise_c);

   // An edge in the closing cycle belongs to the closing window.
   always_ff @(posedge clk250_i or negedge clk250_rst_ni) begin
      if (!clk250_rst_ni) begin
         wc_q         <= '0;
         edge_cnt_q   <= '0;
         edge_count_o <= '0;
      end else begin
         if (win_last_c) begin
            wc_q         <= '0;
            edge_cnt_q   <= '0;
            edge_count_o <= count_sat_c;
         end else begin
            wc_q         <= wc_q + WC_W'(1);
            edge_cnt_q   <= count_sat_c;
         end
      end
   end

   always_comb begin
      win_cls_c = CLS_NONE;
      if (32'(count_sat_c) >= thr_1000_p) begin
         win_cls_c = CLS_1000;
      end else if (32'(count_sat_c) >= thr_100_p) begin
         win_cls_c = CLS_100;
      end else if (32'(count_sat_c) >= thr_10_p) begin
         win_cls_c = CLS_10;
      end
   end

   // Committed class is the FSM state; candidate/agree track the run of equal windows.
   always_ff @(posedge clk250_i or negedge clk250_rst_ni) begin
      if (!clk250_rst_ni) begin
         committed_q     <= CLS_NONE;
         cand_q          <= CLS_NONE;
         agree_q         <= '0;
         speed_setting_o <= 2'b00;
         speed_valid_o   <= 1'b0;
         speed_change_o  <= 1'b0;
      end else begin
         committed_q     <= committed_d;
         cand_q          <= cand_d;
         agree_q         <= agree_d;
         speed_setting_o <= setting_d;
         speed_valid_o   <= valid_d;
         speed_change_o  <= change_d;
      end
   end

   always_comb begin
      committed_d = committed_q;
      cand_d      = cand_q;
      agree_d     = agree_q;
      setting_d   = speed_setting_o;
      valid_d     = speed_valid_o;
      change_d    = 1'b0;

      if (win_last_c) begin
         if (win_cls_c == cand_q) begin
            if (agree_q != AGREE_MAX) begin
               agree_d = agree_q + AGREE_W'(1);
            end
         end else begin
            cand_d  = win_cls_c;
            agree_d = AGREE_W'(1);
         end

         // No-clock keeps the last setting so the TX clock keeps running.
         if ((agree_d == AGREE_MAX) && (cand_d != committed_q)) begin
            committed_d = cand_d;
            valid_d     = (cand_d != CLS_NONE);
            change_d    = 1'b1;
            if (cand_d != CLS_NONE) begin
               setting_d = 2'(cand_d);
            end
         end
      end
   end

endmodule

// File: tb/tb_rgmii_rx_clk_speed_detector.sv
// Directed bench for rgmii_rx_clk_speed_detector: cycle-aligned RX clock patterns
// with hand-computed window counts, commit cycles and output states.
module tb_rgmii_rx_clk_speed_detector;

   localparam int WIN = 4096;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [1:0] speed_setting;
   logic       speed_valid;
   logic       speed_change;
   logic [9:0] edge_count;

   int vectors     = 0;
   int miscompares = 0;

   int cyc            = 0;
   int pulse_cnt      = 0;
   int last_pulse_cyc = -1;
   int gcyc           = 0;
   int gen_half       = 0;
   int gen_org        = 0;

   always #5 clk = ~clk;

   rgmii_rx_clk_speed_detector dut (
      .clk250_i        (clk),
      .clk250_rst_ni   (rst_n),
      .rx_clk_div8_i   (rx),
      .speed_setting_o (speed_setting),
      .speed_valid_o   (speed_valid),
      .speed_change_o  (speed_change),
      .edge_count_o    (edge_count)
   );

   // cyc = number of clk250 rising edges since reset release, counted at the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            cyc = 0;
         end else begin
            cyc++;
            if (speed_change) begin
               pulse_cnt++;
               last_pulse_cyc = cyc;
            end
         end
      end
   end

   // Square wave locked to the cycle count: rises at gen_org + n*2*gen_half; gen_half==0 holds the level.
   initial begin
      rx = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) gcyc = 0;
         else        gcyc++;
         if (gen_half != 0) begin
            rx = logic'((gcyc >= gen_org) && (((gcyc - gen_org) % (2 * gen_half)) < gen_half));
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic wait_to(input int target);
      while (cyc < target) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_pulse(input int budget, output bit got);
      int p0;
      p0  = pulse_cnt;
      got = 1'b0;
      for (int i = 0; (i < budget) && !got; i++) begin
         @(negedge clk);
         #1;
         if (pulse_cnt != p0) got = 1'b1;
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      #1;
      vectors++;
      if (speed_setting !== 2'b00) begin miscompares++; $display("FAIL reset_setting got=%b exp=00", speed_setting); end
      vectors++;
      if (speed_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", speed_valid); end
      vectors++;
      if (speed_change !== 1'b0) begin miscompares++; $display("FAIL reset_change got=%b exp=0", speed_change); end
      vectors++;
      if (edge_count !== 10'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", edge_count); end
   endtask

   // Edges land on window cycles 15,31,...,4095, so the last-cycle edge must count in window 1.
   task automatic test_1000m();
      bit got;
      wait_to(4100);
      vectors++;
      if (edge_count !== 10'd256) begin miscompares++; $display("FAIL w1_last_cycle_edge got=%0d exp=256", edge_count); end
      wait_to(8196);
      vectors++;
      if (edge_count !== 10'd256) begin miscompares++; $display("FAIL w2_count got=%0d exp=256", edge_count); end
      wait_pulse(2 * WIN, got);
      vectors++;
      if (got !== 1'b1) begin miscompares++; $display("FAIL m1000_pulse got=%0d exp=1", got); end
      vectors++;
      if (last_pulse_cyc != 3 * WIN) begin miscompares++; $display("FAIL m1000_pulse_cycle got=%0d exp=%0d", last_pulse_cyc, 3 * WIN); end
      vectors++;
      if (speed_setting !== 2'b00) begin miscompares++; $display("FAIL m1000_setting got=%b exp=00", speed_setting); end
      vectors++;
      if (speed_valid !== 1'b1) begin miscompares++; $display("FAIL m1000_valid got=%b exp=1", speed_valid); end
      vectors++;
      if (edge_count !== 10'd256) begin miscompares++; $display("FAIL m1000_count got=%0d exp=256", edge_count); end
   endtask

   // Window 4 sees no edges; windows 5..7 re-agree on 1000M which is already committed.
   task automatic test_outlier();
      wait_to(3 * WIN + 8);
      gen_half = 0;
      wait_to(4 * WIN + 8);
      vectors++;
      if (edge_count !== 10'd0) begin miscompares++; $display("FAIL outlier_count got=%0d exp=0", edge_count); end
      gen_half = 8;
      gen_org  = 13;
      wait_to(7 * WIN + 8);
      vectors++;
      if (pulse_cnt != 1) begin miscompares++; $display("FAIL outlier_pulses got=%0d exp=1", pulse_cnt); end
      vectors++;
      if (speed_setting !== 2'b00) begin miscompares++; $display("FAIL outlier_setting got=%b exp=00", speed_setting); end
      vectors++;
      if (speed_valid !== 1'b1) begin miscompares++; $display("FAIL outlier_valid got=%b exp=1", speed_valid); end
      vectors++;
      if (edge_count !== 10'd256) begin miscompares++; $display("FAIL outlier_recover_count got=%0d exp=256", edge_count); end
   endtask

   task automatic test_100m();
      bit got;
      gen_half = 40;
      gen_org  = cyc + 1;
      wait_pulse(4 * WIN + 16, got);
      vectors++;
      if (got !== 1'b1) begin miscompares++; $display("FAIL m100_pulse got=%0d exp=1", got); end
      vectors++;
      if (speed_setting !== 2'b01) begin miscompares++; $display("FAIL m100_setting got=%b exp=01", speed_setting); end
      vectors++;
      if (speed_valid !== 1'b1) begin miscompares++; $display("FAIL m100_valid got=%b exp=1", speed_valid); end
      vectors++;
      if ((edge_count !== 10'd51) && (edge_count !== 10'd52)) begin
         miscompares++; $display("FAIL m100_count got=%0d exp=51..52", edge_count);
      end
   endtask

   task automatic test_10m();
      bit got;
      wait_to(cyc + 8);
      gen_half = 400;
      gen_org  = cyc + 1;
      wait_pulse(4 * WIN + 16, got);
      vectors++;
      if (got !== 1'b1) begin miscompares++; $display("FAIL m10_pulse got=%0d exp=1", got); end
      vectors++;
      if (speed_setting !== 2'b10) begin miscompares++; $display("FAIL m10_setting got=%b exp=10", speed_setting); end
      vectors++;
      if (speed_valid !== 1'b1) begin miscompares++; $display("FAIL m10_valid got=%b exp=1", speed_valid); end
      vectors++;
      if ((edge_count !== 10'd5) && (edge_count !== 10'd6)) begin
         miscompares++; $display("FAIL m10_count got=%0d exp=5..6", edge_count);
      end
   endtask

   task automatic test_no_clock();
      bit got;
      wait_to(cyc + 8);
      gen_half = 0;
      wait_pulse(4 * WIN + 16, got);
      vectors++;
      if (got !== 1'b1) begin miscompares++; $display("FAIL noclk_pulse got=%0d exp=1", got); end
      vectors++;
      if (speed_valid !== 1'b0) begin miscompares++; $display("FAIL noclk_valid got=%b exp=0", speed_valid); end
      vectors++;
      if (speed_setting !== 2'b10) begin miscompares++; $display("FAIL noclk_setting_held got=%b exp=10", speed_setting); end
      vectors++;
      if (edge_count !== 10'd0) begin miscompares++; $display("FAIL noclk_count got=%0d exp=0", edge_count); end
   endtask

   // Period-4 input gives 1024 edges per window, one more than the counter can hold.
   task automatic test_overload();
      bit got;
      wait_to(cyc + 8);
      gen_half = 2;
      gen_org  = cyc + 1;
      wait_pulse(4 * WIN + 16, got);
      vectors++;
      if (got !== 1'b1) begin miscompares++; $display("FAIL ovl_pulse got=%0d exp=1", got); end
      vectors++;
      if (edge_count !== 10'd1023) begin miscompares++; $display("FAIL ovl_saturate got=%0d exp=1023", edge_count); end
      vectors++;
      if (speed_setting !== 2'b00) begin miscompares++; $display("FAIL ovl_setting got=%b exp=00", speed_setting); end
      vectors++;
      if (speed_valid !== 1'b1) begin miscompares++; $display("FAIL ovl_valid got=%b exp=1", speed_valid); end
   endtask

   // Reset between clock edges must clear outputs at once; release restarts the window at 0.
   task automatic test_async_reset();
      int p_before;
      wait_to(cyc + 8);
      p_before = pulse_cnt;
      rst_n    = 1'b0;
      #1;
      vectors++;
      if (speed_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got=%b exp=0", speed_valid); end
      vectors++;
      if (edge_count !== 10'd0) begin miscompares++; $display("FAIL arst_count got=%0d exp=0", edge_count); end
      vectors++;
      if (speed_setting !== 2'b00) begin miscompares++; $display("FAIL arst_setting got=%b exp=00", speed_setting); end
      vectors++;
      if (speed_change !== 1'b0) begin miscompares++; $display("FAIL arst_change got=%b exp=0", speed_change); end
      repeat (3) @(negedge clk);
      gen_half = 8;
      gen_org  = 13;
      release_reset();
      wait_to(WIN - 2);
      vectors++;
      if (edge_count !== 10'd0) begin miscompares++; $display("FAIL restart_early_count got=%0d exp=0", edge_count); end
      wait_to(WIN + 4);
      vectors++;
      if (edge_count !== 10'd256) begin miscompares++; $display("FAIL restart_w1_count got=%0d exp=256", edge_count); end
      vectors++;
      if (pulse_cnt != p_before) begin miscompares++; $display("FAIL restart_pulses got=%0d exp=%0d", pulse_cnt, p_before); end
      vectors++;
      if (speed_valid !== 1'b0) begin miscompares++; $display("FAIL restart_valid got=%b exp=0", speed_valid); end
   endtask

   initial begin
      rst_n    = 1'b0;
      gen_half = 8;
      gen_org  = 13;
      test_reset();
      release_reset();
      test_1000m();
      test_outlier();
      test_100m();
      test_10m();
      test_no_clock();
      test_overload();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
